// File: rtl/warp_register_if.sv
// Bundle for the warp register file ports: warp_selector, one lane-masked write
// port and two lane-masked read ports.
interface warp_register_if #(
  parameter int WARP_W     = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_WIDTH = 64
);
  logic [WARP_W-1:0]     warp_selector;
  logic [7:0]            write_en;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_WIDTH-1:0] wdata_0, wdata_1, wdata_2, wdata_3;
  logic [DATA_WIDTH-1:0] wdata_4, wdata_5, wdata_6, wdata_7;
  logic [7:0]            read_en_0;
  logic [ADDR_W-1:0]     raddr_0;
  logic [7:0]            read_en_1;
  logic [ADDR_W-1:0]     raddr_1;
  logic [DATA_WIDTH-1:0] rdata_0_0, rdata_0_1, rdata_0_2, rdata_0_3;
  logic [DATA_WIDTH-1:0] rdata_0_4, rdata_0_5, rdata_0_6, rdata_0_7;
  logic [DATA_WIDTH-1:0] rdata_1_0, rdata_1_1, rdata_1_2, rdata_1_3;
  logic [DATA_WIDTH-1:0] rdata_1_4, rdata_1_5, rdata_1_6, rdata_1_7;

  // operand-fetch / writeback side
  modport master (
    output warp_selector, write_en, waddr,
    output wdata_0, wdata_1, wdata_2, wdata_3, wdata_4, wdata_5, wdata_6, wdata_7,
    output read_en_0, raddr_0, read_en_1, raddr_1,
    input  rdata_0_0, rdata_0_1, rdata_0_2, rdata_0_3,
    input  rdata_0_4, rdata_0_5, rdata_0_6, rdata_0_7,
    input  rdata_1_0, rdata_1_1, rdata_1_2, rdata_1_3,
    input  rdata_1_4, rdata_1_5, rdata_1_6, rdata_1_7
  );

  // register file side
  modport slave (
    input  warp_selector, write_en, waddr,
    input  wdata_0, wdata_1, wdata_2, wdata_3, wdata_4, wdata_5, wdata_6, wdata_7,
    input  read_en_0, raddr_0, read_en_1, raddr_1,
    output rdata_0_0, rdata_0_1, rdata_0_2, rdata_0_3,
    output rdata_0_4, rdata_0_5, rdata_0_6, rdata_0_7,
    output rdata_1_0, rdata_1_1, rdata_1_2, rdata_1_3,
    output rdata_1_4, rdata_1_5, rdata_1_6, rdata_1_7
  );
endinterface

// File: rtl/warp_register_block.sv
// Per-warp, per-lane GPR file for an 8-lane SIMT datapath.
// Each lane owns its own slice of storage (all warps x all registers); one write
// port and two independent combinational read ports, no write-to-read bypass.

// One lane's storage for every warp context.
module warp_register_lane #(
  parameter int NUM_WARPS  = 16,
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 64,
  localparam int WARP_W    = $clog2(NUM_WARPS),
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WARP_W-1:0]     warp_selector,
  input  logic                  write_en,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  read_en_0,
  input  logic [ADDR_W-1:0]     raddr_0,
  input  logic                  read_en_1,
  input  logic [ADDR_W-1:0]     raddr_1,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic [DATA_WIDTH-1:0] rdata_1
);
  logic [DATA_WIDTH-1:0] regs [NUM_WARPS][NUM_REGS];

  // Reset clears every warp's registers and wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++)
        for (int r = 0; r < NUM_REGS; r++)
          regs[w][r] <= '0;
    end else if (write_en) begin
      regs[warp_selector][waddr] <= wdata;
    end
  end

  // Zero-latency reads of the pre-edge contents; disabled lanes drive zero.
  always_comb begin
    rdata_0 = '0;
    rdata_1 = '0;
    if (read_en_0) rdata_0 = regs[warp_selector][raddr_0];
    if (read_en_1) rdata_1 = regs[warp_selector][raddr_1];
  end
endmodule

module warp_register_block #(
  parameter int NUM_WARPS  = 16,
  parameter int NUM_LANES  = 8,
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  warp_register_if.slave bus
);
  localparam int WARP_W = $clog2(NUM_WARPS);
  localparam int ADDR_W = $clog2(NUM_REGS);

  // Lane-indexed views of the flat per-lane port signals.
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] wdata;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rdata_0;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rdata_1;
  logic [WARP_W-1:0]                    warp_selector;
  logic [ADDR_W-1:0]                    waddr, raddr_0, raddr_1;
  logic [NUM_LANES-1:0]                 write_en, read_en_0, read_en_1;

  assign warp_selector = bus.warp_selector;
  assign waddr         = bus.waddr;
  assign raddr_0       = bus.raddr_0;
  assign raddr_1       = bus.raddr_1;
  assign write_en      = bus.write_en;
  assign read_en_0     = bus.read_en_0;
  assign read_en_1     = bus.read_en_1;

  assign wdata[0] = bus.wdata_0;
  assign wdata[1] = bus.wdata_1;
  assign wdata[2] = bus.wdata_2;
  assign wdata[3] = bus.wdata_3;
  assign wdata[4] = bus.wdata_4;
  assign wdata[5] = bus.wdata_5;
  assign wdata[6] = bus.wdata_6;
  assign wdata[7] = bus.wdata_7;

  assign bus.rdata_0_0 = rdata_0[0];
  assign bus.rdata_0_1 = rdata_0[1];
  assign bus.rdata_0_2 = rdata_0[2];
  assign bus.rdata_0_3 = rdata_0[3];
  assign bus.rdata_0_4 = rdata_0[4];
  assign bus.rdata_0_5 = rdata_0[5];
  assign bus.rdata_0_6 = rdata_0[6];
  assign bus.rdata_0_7 = rdata_0[7];
  assign bus.rdata_1_0 = rdata_1[0];
  assign bus.rdata_1_1 = rdata_1[1];
  assign bus.rdata_1_2 = rdata_1[2];
  assign bus.rdata_1_3 = rdata_1[3];
  assign bus.rdata_1_4 = rdata_1[4];
  assign bus.rdata_1_5 = rdata_1[5];
  assign bus.rdata_1_6 = rdata_1[6];
  assign bus.rdata_1_7 = rdata_1[7];

  // Lanes never interact, so each gets an independent storage slice.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    warp_register_lane #(
      .NUM_WARPS (NUM_WARPS),
      .NUM_REGS  (NUM_REGS),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .warp_selector(warp_selector),
      .write_en     (write_en[k]),
      .waddr        (waddr),
      .wdata        (wdata[k]),
      .read_en_0    (read_en_0[k]),
      .raddr_0      (raddr_0),
      .read_en_1    (read_en_1[k]),
      .raddr_1      (raddr_1),
      .rdata_0      (rdata_0[k]),
      .rdata_1      (rdata_1[k])
    );
  end
endmodule

// File: tb/tb_warp_register_block.sv
// Directed bench for warp_register_block: reset, readback, dual read, lane
// masking, warp isolation sweep, read-during-write and mid-operation reset.
module tb_warp_register_block;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  warp_register_if bus ();

  warp_register_block dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0][63:0] rd0, rd1;
  assign rd0[0] = bus.rdata_0_0;
  assign rd0[1] = bus.rdata_0_1;
  assign rd0[2] = bus.rdata_0_2;
  assign rd0[3] = bus.rdata_0_3;
  assign rd0[4] = bus.rdata_0_4;
  assign rd0[5] = bus.rdata_0_5;
  assign rd0[6] = bus.rdata_0_6;
  assign rd0[7] = bus.rdata_0_7;
  assign rd1[0] = bus.rdata_1_0;
  assign rd1[1] = bus.rdata_1_1;
  assign rd1[2] = bus.rdata_1_2;
  assign rd1[3] = bus.rdata_1_3;
  assign rd1[4] = bus.rdata_1_4;
  assign rd1[5] = bus.rdata_1_5;
  assign rd1[6] = bus.rdata_1_6;
  assign rd1[7] = bus.rdata_1_7;

  logic [63:0] model [16][32][8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_wdata(input logic [7:0][63:0] d);
    bus.wdata_0 = d[0]; bus.wdata_1 = d[1]; bus.wdata_2 = d[2]; bus.wdata_3 = d[3];
    bus.wdata_4 = d[4]; bus.wdata_5 = d[5]; bus.wdata_6 = d[6]; bus.wdata_7 = d[7];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0][63:0] wv, base;
  logic [31:0]      r32;

  initial begin
    rst_n             = 1'b0;
    bus.warp_selector = '0;
    bus.write_en      = '0;
    bus.waddr         = '0;
    bus.read_en_0     = '0;
    bus.raddr_0       = '0;
    bus.read_en_1     = '0;
    bus.raddr_1       = '0;
    set_wdata('0);
    tick();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rst_dis_p0_l%0d", k), rd0[k], 64'h0);
      chk($sformatf("rst_dis_p1_l%0d", k), rd1[k], 64'h0);
    end

    // reset then read with all lanes enabled
    bus.read_en_0 = 8'hFF;
    bus.read_en_1 = 8'hFF;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rst_rd_p0_l%0d", k), rd0[k], 64'h0);
      chk($sformatf("rst_rd_p1_l%0d", k), rd1[k], 64'h0);
    end
    bus.read_en_0 = 8'h00;
    bus.read_en_1 = 8'h00;

    // all-lane write to warp 3, reg 0x0A
    for (int k = 0; k < 8; k++) base[k] = 64'h1000_0000_0000_0000 | 64'(k);
    bus.warp_selector = 4'd3;
    bus.waddr         = 5'h0A;
    bus.write_en      = 8'hFF;
    set_wdata(base);
    tick();
    bus.write_en  = 8'h00;
    bus.read_en_0 = 8'hFF;
    bus.raddr_0   = 5'h0A;
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("wr_p0_l%0d", k), rd0[k], base[k]);
    bus.read_en_0 = 8'h00;
    bus.read_en_1 = 8'hFF;
    bus.raddr_1   = 5'h0A;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wr_p1_l%0d", k), rd1[k], base[k]);
      chk($sformatf("wr_p0off_l%0d", k), rd0[k], 64'h0);
    end

    // dual-port read of the same address
    bus.read_en_0 = 8'hFF;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("dual_p0_l%0d", k), rd0[k], base[k]);
      chk($sformatf("dual_p1_l%0d", k), rd1[k], base[k]);
    end

    // lane-masked write: only lanes 0 and 2 take all-ones
    bus.write_en = 8'h05;
    set_wdata({8{64'hFFFF_FFFF_FFFF_FFFF}});
    tick();
    bus.write_en = 8'h00;
    #1;
    for (int k = 0; k < 8; k++)
      chk($sformatf("mask_p1_l%0d", k), rd1[k],
          (k == 0 || k == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : base[k]);
    bus.read_en_0 = 8'h0F;
    #1;
    for (int k = 0; k < 8; k++)
      chk($sformatf("mask_ren_p0_l%0d", k), rd0[k],
          (k >= 4) ? 64'h0 : ((k == 0 || k == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : base[k]));

    // warp isolation sweep
    for (int w = 0; w < 16; w++) begin
      for (int r = 0; r < 32; r++) begin
        for (int k = 0; k < 8; k++) begin
          r32 = $urandom;
          wv[k] = {{32{r32[31]}}, r32};
          model[w][r][k] = wv[k];
        end
        bus.warp_selector = 4'(w);
        bus.waddr         = 5'(r);
        bus.write_en      = 8'hFF;
        bus.read_en_0     = 8'h00;
        bus.read_en_1     = 8'h00;
        set_wdata(wv);
        tick();
        bus.write_en  = 8'h00;
        bus.raddr_0   = 5'(r);
        bus.raddr_1   = 5'(r);
        bus.read_en_0 = 8'hFF;
        #1;
        for (int k = 0; k < 8; k++) chk($sformatf("sw_p0_w%0d_r%0d_l%0d", w, r, k), rd0[k], model[w][r][k]);
        bus.read_en_0 = 8'h00;
        bus.read_en_1 = 8'hFF;
        #1;
        for (int k = 0; k < 8; k++) chk($sformatf("sw_p1_w%0d_r%0d_l%0d", w, r, k), rd1[k], model[w][r][k]);
        bus.read_en_0 = 8'hFF;
        #1;
        for (int k = 0; k < 8; k++) begin
          chk($sformatf("sw_b0_w%0d_r%0d_l%0d", w, r, k), rd0[k], model[w][r][k]);
          chk($sformatf("sw_b1_w%0d_r%0d_l%0d", w, r, k), rd1[k], model[w][r][k]);
        end
      end
    end

    // revisit warp 0, different addresses on the two ports
    bus.warp_selector = 4'd0;
    bus.read_en_0     = 8'hFF;
    bus.read_en_1     = 8'hFF;
    for (int r = 0; r < 32; r++) begin
      bus.raddr_0 = 5'(r);
      bus.raddr_1 = 5'(31 - r);
      #1;
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("w0_p0_r%0d_l%0d", r, k), rd0[k], model[0][r][k]);
        chk($sformatf("w0_p1_r%0d_l%0d", 31 - r, k), rd1[k], model[0][31 - r][k]);
      end
    end

    // warp switch redirects reads without a clock edge
    bus.raddr_0 = 5'd7;
    bus.raddr_1 = 5'd7;
    bus.warp_selector = 4'd9;
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("wsw_p0_l%0d", k), rd0[k], model[9][7][k]);

    // read-during-write returns old data, new data after the edge
    bus.warp_selector = 4'd7;
    bus.waddr         = 5'h05;
    bus.write_en      = 8'hFF;
    set_wdata({8{64'hA}});
    tick();
    bus.raddr_0 = 5'h05;
    set_wdata({8{64'hB}});
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("rdw_pre_l%0d", k), rd0[k], 64'hA);
    tick();
    bus.write_en = 8'h00;
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("rdw_post_l%0d", k), rd0[k], 64'hB);

    // reset mid-operation clears all and drops the concurrent write
    rst_n             = 1'b0;
    bus.warp_selector = 4'd2;
    bus.waddr         = 5'h03;
    bus.write_en      = 8'hFF;
    set_wdata({8{64'h55}});
    tick();
    rst_n        = 1'b1;
    bus.write_en = 8'h00;
    bus.raddr_0  = 5'h03;
    bus.raddr_1  = 5'h1F;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mrst_w2_l%0d", k), rd0[k], 64'h0);
      chk($sformatf("mrst_w2r31_l%0d", k), rd1[k], 64'h0);
    end
    bus.warp_selector = 4'd0;
    #1;
    for (int k = 0; k < 8; k++) chk($sformatf("mrst_w0_l%0d", k), rd0[k], 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/warp_register_block.md
Name: warp_register_block

Overview:
- Per-warp, per-lane general-purpose register file for an 8-lane SIMT datapath.
- Holds 32 x 64-bit registers for each of 8 lanes in each of 16 warps.
- Has one write port and two read ports. Each port is lane-masked and addressed into the warp chosen by warp_selector.
- Sits between the operand-fetch stage (reads) and the writeback stage (writes).

Parameters:
- NUM_WARPS, 16, number of warp contexts; warp_selector width is log2(NUM_WARPS).
- NUM_LANES, 8, lanes per warp. Ports are fixed at 8; the value is for documentation and assertions only.
- NUM_REGS, 32, registers per lane; address width is log2(NUM_REGS).
- DATA_WIDTH, 64, register width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- warp_selector  in  4  warp context used by all three ports this cycle.
- write_en  in  8  per-lane write enable; bit k controls lane k.
- waddr  in  5  write register address.
- wdata_0 .. wdata_7  in  64 each  write data for lanes 0..7.
- read_en_0  in  8  per-lane enable for read port 0.
- raddr_0  in  5  read port 0 register address.
- read_en_1  in  8  per-lane enable for read port 1.
- raddr_1  in  5  read port 1 register address.
- rdata_0_0 .. rdata_0_7  out  64 each  port 0 read data, lanes 0..7.
- rdata_1_0 .. rdata_1_7  out  64 each  port 1 read data, lanes 0..7.

Behaviour:
- Storage: regs[warp][lane][addr], 16 x 8 x 32 x 64 bits.
- Reset:
  - On a rising edge with rst_n=0, every register in every warp and lane is cleared to 0.
  - Writes are ignored in a reset cycle.
  - Reset asserted mid-operation takes effect at the next edge and discards any write presented that cycle.
- Write:
  - On a rising edge with rst_n=1, for each lane k with write_en[k]=1: regs[warp_selector][k][waddr] <= wdata_k.
  - Lanes with write_en[k]=0 are untouched. Other warps and other addresses are untouched.
  - Single-cycle write; no handshake or back-pressure.
- Read:
  - Combinational (asynchronous) with zero latency.
  - rdata_p_k = regs[warp_selector][k][raddr_p] when read_en_p[k]=1, else 64'h0.
  - Outputs follow the address, enable and warp_selector inputs within the same cycle, before the next clock edge.
- Dual read:
  - Ports 0 and 1 are fully independent.
  - Both may read the same or different addresses simultaneously, with identical results for the same address.
- Read-during-write:
  - A read of the address being written in the same cycle returns the old (pre-edge) value; there is no bypass.
  - The new value is visible immediately after the rising edge.
- Warp switching:
  - A change of warp_selector redirects all ports at once.
  - The data of non-selected warps is retained indefinitely.
- Address wrap: 5-bit addresses cover all 32 registers exactly; there are no out-of-range cases.
- Output reset value: with all read_en=0 after reset, all rdata outputs are 0. With read_en set after reset and no writes, they also read 0 (storage is cleared).

Test Plan:
- Reset then read:
  - Stimulus: rst_n=0 for one edge, then warp 0, read_en_0=read_en_1=8'hFF, raddr 0.
  - Required: all 16 rdata outputs = 64'h0.
- All-lane write/readback:
  - Stimulus: warp 3, waddr=5'h0A, write_en=8'hFF, wdata_k=64'h1000_0000_0000_000k for lanes 0..7, one edge.
  - Then: read_en_0=8'hFF, raddr_0=5'h0A.
  - Required: rdata_0_k=wdata_k.
  - Then: read_en_0=8'h00, read_en_1=8'hFF, raddr_1=5'h0A.
  - Required: rdata_1_k=wdata_k and all rdata_0_k=0.
- Dual-port simultaneous read:
  - Stimulus: after the previous write, both ports enabled at address 5'h0A.
  - Required: rdata_0_k and rdata_1_k both equal wdata_k for every lane.
- Lane masking:
  - Stimulus: write_en=8'h05, wdata=all-ones, to an address holding known data.
  - Required: only lanes 0 and 2 change.
  - Stimulus: read_en_0=8'h0F.
  - Required: lanes 4..7 of port 0 read 0.
- Warp isolation sweep:
  - Stimulus: for each warp 0..15 and each register 0..31, write distinct random values (sign-extended 32-bit) to all lanes and read back through port 0, port 1, then both ports.
  - Required: every readback matches the written value.
  - Then: revisit warp 0.
  - Required: data unaffected by writes to other warps.
- Read-during-write:
  - Stimulus: raddr_0=waddr=5'h05 holding 64'hA, write 64'hB in the same cycle.
  - Required: before the edge rdata_0 = 64'hA; after the edge = 64'hB.
